front_layer_out_writer: RTL and testbench
=========================================

FRONT_LAYER_OUT_WRITER -- requirements
Module: front_layer_out_writer

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of one signed feature-map sample.
REQ-002 Parameter OUTPUT_WIDTH, default 28, output columns per row.
REQ-003 Parameter OUTPUT_HEIGTH, default 28, output rows.
REQ-004 Parameter OUTPUT_FEATURE_MAP, default 6, lanes packed per output word.
REQ-005 Parameter OUT_DEPTH, default 784, output RAM depth (OUTPUT_WIDTH*OUTPUT_HEIGTH).
REQ-006 Parameter RELU_EN, default 1, enables per-lane ReLU before write.
REQ-007 Port clk, input, 1, single clock; all logic on rising edge.
REQ-008 Port rst, input, 1, synchronous active-high reset.
REQ-009 Port start, input, 1, one-cycle pulse beginning one feature-map pass.
REQ-010 Port in_valid, input, 1, conv result present on in_data.
REQ-011 Port in_data, input, OUTPUT_FEATURE_MAP*DATA_WIDTH, packed results, lane 0 in LSBs.
REQ-012 Port in_ready, output, 1, writer accepts in_data this cycle.
REQ-013 Port wr_en, output, 1, output RAM write request.
REQ-014 Port wr_ready, input, 1, RAM accepts write this cycle.
REQ-015 Port wr_addr, output, 10, output RAM word address.
REQ-016 Port wr_data, output, OUTPUT_FEATURE_MAP*DATA_WIDTH, word to write.
REQ-017 Port out_cell_row, output, 5, row of next accepted result.
REQ-018 Port out_cell_col, output, 5, column of next accepted result.
REQ-019 Port st, output, 4, one-hot state.
REQ-020 Port done, output, 1, one-cycle pulse when pass fully written.

Function
REQ-021 States SHALL be one-hot: IDLE 4'b0001, WRITE 4'b0010, FLUSH 4'b0100, DONE 4'b1000.
REQ-022 IDLE->WRITE on start; counters, accept count and wr_addr cleared that edge; start outside IDLE ignored.
REQ-023 Writer SHALL hold a single-entry output register; wr_en equals register-full.
REQ-024 in_ready = (st==WRITE) & (accept_cnt<OUT_DEPTH) & (!full | wr_ready), combinational.
REQ-025 Accept = in_valid & in_ready: register loads (ReLU'd) in_data; accept_cnt, column/row advance.
REQ-026 Write = wr_en & wr_ready: wr_addr increments by 1 on the edge; register empties unless simultaneously reloaded.
REQ-027 Simultaneous accept and write SHALL sustain one word per cycle with no bubble.
REQ-028 wr_en, wr_addr, wr_data SHALL hold stable while wr_en & !wr_ready.
REQ-029 out_cell_col counts 0..OUTPUT_WIDTH-1, wraps to 0 and increments out_cell_row; row saturates at OUTPUT_HEIGTH after last accept.
REQ-030 wr_addr = row*OUTPUT_WIDTH+col of the word in the register; first write at 0, last at OUT_DEPTH-1.
REQ-031 ReLU: when RELU_EN=1, each lane with MSB set becomes zero; otherwise passthrough.
REQ-032 WRITE->FLUSH on the edge accepting result OUT_DEPTH; FLUSH->DONE on the edge the final write completes (same edge allowed from WRITE if wr_ready).
REQ-033 DONE lasts one cycle with done=1, then IDLE; in_ready=0 outside WRITE.
REQ-034 in_valid in IDLE/FLUSH/DONE SHALL be ignored and no data dropped silently counted.

Reset
REQ-035 rst SHALL force st=IDLE, wr_en=0, register empty, wr_addr=0, accept_cnt=0, out_cell_row=0, out_cell_col=0, done=0, wr_data=0.
REQ-036 rst mid-pass SHALL abandon the pass; pending write discarded, no done pulse.
REQ-037 rst has priority over start, accept and write in the same cycle.

Structure
REQ-038 State encodings, DATA_WIDTH, OUTPUT_WIDTH, OUTPUT_HEIGTH, OUTPUT_FEATURE_MAP, OUT_DEPTH SHALL live in a shared lenet5 package.
REQ-039 ReLU lane array SHALL be a sub-module relu_lanes (combinational, parameterised by lane count/width).

Verification
REQ-040 Reset, start, 784 back-to-back valid, wr_ready=1 -> 784 writes addr 0..783 consecutive cycles, done one cycle after last write.
REQ-041 Lane 2 = 16'hFFF0, others 16'h0005, RELU_EN=1 -> wr_data lane 2 = 0, others 5; RELU_EN=0 -> unchanged.
REQ-042 wr_ready low 3 cycles at addr 27 -> wr_addr/wr_data held, in_ready=0, out_cell_row becomes 1 col 0 after accept 28.
REQ-043 rst asserted after 100 writes -> st=IDLE, wr_en=0, wr_addr=0 next cycle, no done.
REQ-044 start pulse during WRITE, in_valid in IDLE -> ignored, counts unchanged.
REQ-045 wr_ready low on final word -> st=FLUSH until write, then DONE, done=1 exactly once.

Source files
------------

// File: rtl/lenet5_pkg.sv
// Shared LeNet-5 dimensions and the output-writer state encoding.
package lenet5_pkg;

   localparam int LN_DATA_WIDTH         = 16;
   localparam int LN_OUTPUT_WIDTH       = 28;
   localparam int LN_OUTPUT_HEIGTH      = 28;
   localparam int LN_OUTPUT_FEATURE_MAP = 6;
   localparam int LN_OUT_DEPTH          = LN_OUTPUT_WIDTH * LN_OUTPUT_HEIGTH;

   typedef enum logic [3:0] {
      ST_IDLE  = 4'b0001,
      ST_WRITE = 4'b0010,
      ST_FLUSH = 4'b0100,
      ST_DONE  = 4'b1000
   } wr_state_e;

endpackage

// File: rtl/relu_lanes.sv
// Per-lane ReLU over a packed vector of signed samples; lane 0 in the LSBs.
module relu_lanes #(
   parameter int LANES = 6,
   parameter int WIDTH = 16,
   parameter int EN    = 1
) (
   input  logic [LANES*WIDTH-1:0] d_i,
   output logic [LANES*WIDTH-1:0] q_o
);

   always_comb begin
      q_o = d_i;
      if (EN != 0) begin
         for (int l = 0; l < LANES; l++) begin
            if (d_i[l*WIDTH+WIDTH-1]) q_o[l*WIDTH +: WIDTH] = '0;
         end
      end
   end

endmodule

// File: rtl/front_layer_out_writer.sv
// Streams conv results through a one-entry output register into the
// feature-map RAM, tracking the row/column of the next accepted result.
module front_layer_out_writer
   import lenet5_pkg::*;
#(
   parameter int DATA_WIDTH         = LN_DATA_WIDTH,
   parameter int OUTPUT_WIDTH       = LN_OUTPUT_WIDTH,
   parameter int OUTPUT_HEIGTH      = LN_OUTPUT_HEIGTH,
   parameter int OUTPUT_FEATURE_MAP = LN_OUTPUT_FEATURE_MAP,
   parameter int OUT_DEPTH          = LN_OUT_DEPTH,
   parameter int RELU_EN            = 1
) (
   input  logic                                   clk,
   input  logic                                   rst,
   input  logic                                   start,
   input  logic                                   in_valid,
   input  logic [OUTPUT_FEATURE_MAP*DATA_WIDTH-1:0] in_data,
   output logic                                   in_ready,
   output logic                                   wr_en,
   input  logic                                   wr_ready,
   output logic [9:0]                             wr_addr,
   output logic [OUTPUT_FEATURE_MAP*DATA_WIDTH-1:0] wr_data,
   output logic [4:0]                             out_cell_row,
   output logic [4:0]                             out_cell_col,
   output logic [3:0]                             st,
   output logic                                   done
);

   localparam int DW = OUTPUT_FEATURE_MAP * DATA_WIDTH;
   localparam int CW = $clog2(OUT_DEPTH + 1);

   wr_state_e         state_q, state_d;
   logic              full_q, full_d;
   logic [DW-1:0]     data_q, data_d;
   logic [9:0]        addr_q, addr_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic [4:0]        row_q, row_d;
   logic [4:0]        col_q, col_d;
   logic [DW-1:0]     relu_data;
   logic              acc, wr;

   relu_lanes #(
      .LANES(OUTPUT_FEATURE_MAP),
      .WIDTH(DATA_WIDTH),
      .EN   (RELU_EN)
   ) u_relu (
      .d_i(in_data),
      .q_o(relu_data)
   );

   // The register may refill on the same edge it drains, so a
   // ready RAM never stalls the input stream.
   always_comb begin
      in_ready = (state_q == ST_WRITE) && (cnt_q < CW'(OUT_DEPTH))
                 && (!full_q || wr_ready);
      acc      = in_valid && in_ready;
      wr       = full_q && wr_ready;
   end

   always_comb begin
      state_d = state_q;
      full_d  = full_q;
      data_d  = data_q;
      addr_d  = addr_q;
      cnt_d   = cnt_q;
      row_d   = row_q;
      col_d   = col_q;

      if (wr) begin
         addr_d = addr_q + 10'd1;
         full_d = 1'b0;
      end
      if (acc) begin
         full_d = 1'b1;
         data_d = relu_data;
         cnt_d  = cnt_q + 1'b1;
         if (col_q == 5'(OUTPUT_WIDTH - 1)) begin
            col_d = '0;
            if (row_q != 5'(OUTPUT_HEIGTH)) row_d = row_q + 5'd1;
         end else begin
            col_d = col_q + 5'd1;
         end
      end

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_WRITE;
               full_d  = 1'b0;
               addr_d  = '0;
               cnt_d   = '0;
               row_d   = '0;
               col_d   = '0;
            end
         end
         ST_WRITE: begin
            if (acc && cnt_q == CW'(OUT_DEPTH - 1)) state_d = ST_FLUSH;
         end
         ST_FLUSH: begin
            if (wr) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         full_q  <= 1'b0;
         data_q  <= '0;
         addr_q  <= '0;
         cnt_q   <= '0;
         row_q   <= '0;
         col_q   <= '0;
      end else begin
         state_q <= state_d;
         full_q  <= full_d;
         data_q  <= data_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         row_q   <= row_d;
         col_q   <= col_d;
      end
   end

   assign wr_en        = full_q;
   assign wr_addr      = addr_q;
   assign wr_data      = data_q;
   assign out_cell_row = row_q;
   assign out_cell_col = col_q;
   assign st           = state_q;
   assign done         = (state_q == ST_DONE);

endmodule

// File: tb/tb_front_layer_out_writer.sv
// Self-checking bench: ReLU vector table, directed corner sequences and
// full passes checked against a queue-based write model.
module tb_front_layer_out_writer;

   localparam int DW    = 96;
   localparam int DEPTH = 784;
   localparam int W     = 28;

   logic          clk = 1'b0;
   logic          rst, start, in_valid, wr_ready;
   logic [DW-1:0] in_data;
   logic          in_ready, wr_en, done;
   logic [9:0]    wr_addr;
   logic [DW-1:0] wr_data;
   logic [4:0]    out_cell_row, out_cell_col;
   logic [3:0]    st;

   logic          np_in_ready, np_wr_en, np_done;
   logic [9:0]    np_wr_addr;
   logic [DW-1:0] np_wr_data;
   logic [4:0]    np_row, np_col;
   logic [3:0]    np_st;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   front_layer_out_writer #(.RELU_EN(1)) dut (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready), .wr_en(wr_en),
      .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .out_cell_row(out_cell_row), .out_cell_col(out_cell_col),
      .st(st), .done(done)
   );

   front_layer_out_writer #(.RELU_EN(0)) dut_np (
      .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
      .in_data(in_data), .in_ready(np_in_ready), .wr_en(np_wr_en),
      .wr_ready(wr_ready), .wr_addr(np_wr_addr), .wr_data(np_wr_data),
      .out_cell_row(np_row), .out_cell_col(np_col),
      .st(np_st), .done(np_done)
   );

   typedef struct {
      logic [DW-1:0] din;
      logic [DW-1:0] relu;
   } vec_t;

   typedef struct {
      logic [9:0]    a;
      logic [DW-1:0] d;
   } wr_t;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [DW-1:0] relu_m(input logic [DW-1:0] x);
      logic [DW-1:0] r;
      logic [15:0]   v;
      for (int l = 0; l < 6; l++) begin
         v = x[16*l +: 16];
         r[16*l +: 16] = ($signed(v) < 0) ? 16'h0 : v;
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; wr_ready = 1'b0;
      in_data = '0;
      tick(); tick();
      rst = 1'b0;
   endtask

   task automatic run_pass(input int mode);
      wr_t   q[$];
      wr_t   w;
      int    acc_n = 0, wr_n = 0, es = 1, cyc = 0, done_n = 0;
      int    first_wr = -1, last_wr = -1, done_at = -1;
      int    s27 = 0, s783 = 0;
      bit    acc, wrv, exp_ready;
      start = 1'b1; in_valid = 1'b0; wr_ready = 1'b0;
      tick();
      start = 1'b0;
      es = 2;
      while (1) begin
         chk("st", st, es);
         chk("wr_en", wr_en, q.size() != 0);
         if (q.size() != 0) begin
            chk("wr_addr", wr_addr, q[0].a);
            chk("wr_data", wr_data, q[0].d);
         end
         chk("row", out_cell_row, acc_n / W);
         chk("col", out_cell_col, acc_n % W);
         chk("done", done, es == 8);
         if (es == 8) begin
            done_n++;
            done_at = cyc;
         end
         if (es == 1) break;
         if (cyc > 20000) begin
            chk("pass_timeout", 1, 0);
            break;
         end
         in_data = {$urandom, $urandom, $urandom};
         case (mode)
            0: begin in_valid = 1'b1; wr_ready = 1'b1; end
            1: begin
               in_valid = ($urandom % 4) != 0;
               wr_ready = ($urandom % 3) != 0;
            end
            default: begin
               in_valid = 1'b1;
               wr_ready = 1'b1;
               if (q.size() != 0 && q[0].a == 10'd27 && s27 < 3) begin
                  wr_ready = 1'b0; s27++;
               end
               if (q.size() != 0 && q[0].a == 10'd783 && s783 < 3) begin
                  wr_ready = 1'b0; s783++;
               end
            end
         endcase
         #1;
         exp_ready = (es == 2) && (acc_n < DEPTH) && (q.size() == 0 || wr_ready);
         chk("in_ready", in_ready, exp_ready);
         wrv = (q.size() != 0) && wr_ready;
         acc = in_valid && exp_ready;
         if (wrv) begin
            void'(q.pop_front());
            wr_n++;
            if (first_wr < 0) first_wr = cyc;
            last_wr = cyc;
         end
         if (acc) begin
            w.a = 10'(acc_n);
            w.d = relu_m(in_data);
            q.push_back(w);
            acc_n++;
         end
         case (es)
            2: if (acc && acc_n == DEPTH) es = 4;
            4: if (wrv && wr_n == DEPTH) es = 8;
            8: es = 1;
            default: ;
         endcase
         tick();
         cyc++;
      end
      chk("done_pulses", done_n, 1);
      chk("writes", wr_n, DEPTH);
      if (mode == 0) begin
         chk("wr_span", last_wr - first_wr, DEPTH - 1);
         chk("done_lat", done_at, last_wr + 1);
      end
      if (mode == 2) chk("stalls", s27 + s783, 6);
      in_valid = 1'b0;
      wr_ready = 1'b0;
   endtask

   initial begin
      vec_t tbl[5];
      int   nwr;
      tbl[0].din  = {16'h0005, 16'h0005, 16'h0005, 16'hFFF0, 16'h0005, 16'h0005};
      tbl[0].relu = {16'h0005, 16'h0005, 16'h0005, 16'h0000, 16'h0005, 16'h0005};
      tbl[1].din  = {6{16'h8000}};
      tbl[1].relu = '0;
      tbl[2].din  = {6{16'h7FFF}};
      tbl[2].relu = {6{16'h7FFF}};
      tbl[3].din  = {16'h0001, 16'hFFFF, 16'h0000, 16'h8001, 16'h7FFE, 16'h1234};
      tbl[3].relu = {16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h7FFE, 16'h1234};
      tbl[4].din  = {16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h0001};
      tbl[4].relu = {16'h0000, 16'h0001, 16'h0000, 16'h0001, 16'h0000, 16'h0001};

      do_reset();
      chk("rst_st", st, 4'b0001);
      chk("rst_wr_en", wr_en, 0);
      chk("rst_addr", wr_addr, 0);
      chk("rst_data", wr_data, 0);
      chk("rst_row", out_cell_row, 0);
      chk("rst_col", out_cell_col, 0);
      chk("rst_done", done, 0);
      chk("rst_in_ready", in_ready, 0);

      // in_valid while idle is ignored
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; wr_ready = 1'b1;
         in_data = {$urandom, $urandom, $urandom};
         #1;
         chk("idle_in_ready", in_ready, 0);
         tick();
         chk("idle_st", st, 4'b0001);
         chk("idle_col", out_cell_col, 0);
         chk("idle_wr_en", wr_en, 0);
      end
      in_valid = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("start_st", st, 4'b0010);
      for (int i = 0; i < 5; i++) begin
         in_valid = 1'b1; wr_ready = 1'b1;
         in_data = {$urandom, $urandom, $urandom};
         tick();
      end
      in_valid = 1'b0;
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("restart_st", st, 4'b0010);
      chk("restart_col", out_cell_col, 5);
      chk("restart_row", out_cell_row, 0);
      chk("restart_addr", wr_addr, 5);
      chk("restart_wr_en", wr_en, 0);

      // ReLU vectors, then abandon the pass with reset after 100 writes
      do_reset();
      start = 1'b1;
      tick();
      start = 1'b0;
      nwr = 0;
      foreach (tbl[i]) begin
         in_valid = 1'b1; wr_ready = 1'b1;
         in_data = tbl[i].din;
         #1;
         if (wr_en && wr_ready) nwr++;
         tick();
         chk("relu_on", wr_data, tbl[i].relu);
         chk("relu_off", np_wr_data, tbl[i].din);
         chk("relu_addr", wr_addr, i);
      end
      for (int i = 0; i < 400 && nwr < 100; i++) begin
         in_valid = 1'b1; wr_ready = 1'b1;
         in_data = {$urandom, $urandom, $urandom};
         #1;
         if (wr_en && wr_ready) nwr++;
         tick();
      end
      chk("pre_rst_addr", wr_addr, 100);
      rst = 1'b1; start = 1'b1; in_valid = 1'b1; wr_ready = 1'b1;
      tick();
      rst = 1'b0; start = 1'b0; in_valid = 1'b0; wr_ready = 1'b0;
      chk("abort_st", st, 4'b0001);
      chk("abort_wr_en", wr_en, 0);
      chk("abort_addr", wr_addr, 0);
      chk("abort_row", out_cell_row, 0);
      chk("abort_col", out_cell_col, 0);
      chk("abort_data", wr_data, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("abort_no_done", done, 0);
         chk("abort_idle", st, 4'b0001);
      end

      run_pass(0);
      run_pass(1);
      run_pass(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
